// File: rtl/decode_hazard_stage.sv
// Decode stage of a 5-stage MIPS-style pipeline: control decode, register file,
// branch/jump resolution, hazard detection and the D->E pipeline register.
module decode_hazard_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR   = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] InstrD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic                  ValidD,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR-1:0]   WriteRegW,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic [REG_ADDR-1:0]   WriteRegM,
    input  logic [DATA_WIDTH-1:0] ALUOutM,
    output logic                  StallD,
    output logic [1:0]            PCSrcD,
    output logic [DATA_WIDTH-1:0] PCBranchD,
    output logic [DATA_WIDTH-1:0] PCJumpD,
    output logic                  RegWriteE,
    output logic                  MemtoRegE,
    output logic                  MemWriteE,
    output logic                  ALUSrcE,
    output logic                  RegDstE,
    output logic                  ValidE,
    output logic [2:0]            ALUControlE,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] SignImmE,
    output logic [REG_ADDR-1:0]   RsE,
    output logic [REG_ADDR-1:0]   RtE,
    output logic [REG_ADDR-1:0]   RdE,
    output logic [CNT_WIDTH-1:0]  StallCount
);

    localparam int NUM_REGS = 2**REG_ADDR;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_dst;
        logic                  valid;
        logic [2:0]            alu_control;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] sign_imm;
        logic [REG_ADDR-1:0]   rs;
        logic [REG_ADDR-1:0]   rt;
        logic [REG_ADDR-1:0]   rd;
    } e_stage_t;

    logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
    e_stage_t              e_q, e_d;
    logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;

    logic [5:0]            opcode, funct;
    logic [REG_ADDR-1:0]   rs_dec, rt_dec, rd_dec;
    logic                  reg_write_dec, mem_to_reg_dec, mem_write_dec;
    logic                  alu_src_dec, reg_dst_dec, branch_dec, jump_dec;
    logic [2:0]            alu_control_dec;
    logic [DATA_WIDTH-1:0] rd1_dec, rd2_dec, sign_imm_dec;
    logic [DATA_WIDTH-1:0] src_a, src_b;
    logic                  forward_ad, forward_bd, equal_dec;
    logic [REG_ADDR-1:0]   write_reg_e;
    logic                  lw_stall, branch_stall, e_hit, m_hit;
    logic                  unused_shamt;

    assign opcode       = InstrD[31:26];
    assign funct        = InstrD[5:0];
    assign rs_dec       = REG_ADDR'(InstrD[25:21]);
    assign rt_dec       = REG_ADDR'(InstrD[20:16]);
    assign rd_dec       = REG_ADDR'(InstrD[15:11]);
    assign unused_shamt = ^InstrD[10:6];

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        reg_write_dec   = 1'b0;
        mem_to_reg_dec  = 1'b0;
        mem_write_dec   = 1'b0;
        alu_src_dec     = 1'b0;
        reg_dst_dec     = 1'b0;
        branch_dec      = 1'b0;
        jump_dec        = 1'b0;
        alu_control_dec = 3'b000;
        case (opcode)
            OP_RTYPE: begin
                reg_write_dec = 1'b1;
                reg_dst_dec   = 1'b1;
                case (funct)
                    6'b100010: alu_control_dec = 3'b110;
                    6'b100100: alu_control_dec = 3'b000;
                    6'b100101: alu_control_dec = 3'b001;
                    6'b101010: alu_control_dec = 3'b111;
                    default:   alu_control_dec = 3'b010;
                endcase
            end
            OP_LW: begin
                reg_write_dec   = 1'b1;
                alu_src_dec     = 1'b1;
                mem_to_reg_dec  = 1'b1;
                alu_control_dec = 3'b010;
            end
            OP_SW: begin
                alu_src_dec     = 1'b1;
                mem_write_dec   = 1'b1;
                alu_control_dec = 3'b010;
            end
            OP_BEQ:  branch_dec = 1'b1;
            OP_ADDI: begin
                reg_write_dec   = 1'b1;
                alu_src_dec     = 1'b1;
                alu_control_dec = 3'b010;
            end
            OP_J:    jump_dec = 1'b1;
            default: ;
        endcase
    end

    // Write-through: a same-cycle write-back is visible to the decode read.
    assign rd1_dec = (rs_dec == '0) ? '0 :
                     (RegWriteW && WriteRegW == rs_dec) ? ResultW : rf_q[rs_dec];
    assign rd2_dec = (rt_dec == '0) ? '0 :
                     (RegWriteW && WriteRegW == rt_dec) ? ResultW : rf_q[rt_dec];

    assign forward_ad = (rs_dec != '0) && (rs_dec == WriteRegM) && RegWriteM;
    assign forward_bd = (rt_dec != '0) && (rt_dec == WriteRegM) && RegWriteM;
    assign src_a      = forward_ad ? ALUOutM : rd1_dec;
    assign src_b      = forward_bd ? ALUOutM : rd2_dec;
    assign equal_dec  = (src_a == src_b);

    assign sign_imm_dec = {{(DATA_WIDTH-16){InstrD[15]}}, InstrD[15:0]};
    assign PCBranchD    = PCPlus4D + (sign_imm_dec << 2);
    assign PCJumpD      = {PCPlus4D[DATA_WIDTH-1:28], InstrD[25:0], 2'b00};

    assign write_reg_e  = e_q.reg_dst ? e_q.rd : e_q.rt;
    assign lw_stall     = e_q.mem_to_reg && e_q.valid &&
                          (e_q.rt == rs_dec || e_q.rt == rt_dec);
    assign e_hit        = e_q.reg_write &&
                          ((rs_dec != '0 && write_reg_e == rs_dec) ||
                           (rt_dec != '0 && write_reg_e == rt_dec));
    assign m_hit        = MemtoRegM &&
                          ((rs_dec != '0 && WriteRegM == rs_dec) ||
                           (rt_dec != '0 && WriteRegM == rt_dec));
    assign branch_stall = branch_dec && (e_hit || m_hit);

    assign StallD    = ValidD && (lw_stall || branch_stall);
    assign PCSrcD[1] = ValidD && jump_dec;
    assign PCSrcD[0] = ValidD && branch_dec && equal_dec && !StallD;

    always_comb begin
        e_d = '0;
        if (ValidD && !StallD) begin
            e_d.reg_write   = reg_write_dec;
            e_d.mem_to_reg  = mem_to_reg_dec;
            e_d.mem_write   = mem_write_dec;
            e_d.alu_src     = alu_src_dec;
            e_d.reg_dst     = reg_dst_dec;
            e_d.valid       = 1'b1;
            e_d.alu_control = alu_control_dec;
            e_d.rd1         = rd1_dec;
            e_d.rd2         = rd2_dec;
            e_d.sign_imm    = sign_imm_dec;
            e_d.rs          = rs_dec;
            e_d.rt          = rt_dec;
            e_d.rd          = rd_dec;
        end
    end

    assign stall_count_d = (StallD && stall_count_q != '1) ? stall_count_q + 1'b1
                                                          : stall_count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            e_q           <= '0;
            stall_count_q <= '0;
        end else begin
            e_q           <= e_d;
            stall_count_q <= stall_count_d;
        end
    end

    // NOTE: the register file is reset because architectural state must read 0 after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (RegWriteW && WriteRegW != '0) begin
            rf_q[WriteRegW] <= ResultW;
        end
    end

    assign RegWriteE   = e_q.reg_write;
    assign MemtoRegE   = e_q.mem_to_reg;
    assign MemWriteE   = e_q.mem_write;
    assign ALUSrcE     = e_q.alu_src;
    assign RegDstE     = e_q.reg_dst;
    assign ValidE      = e_q.valid;
    assign ALUControlE = e_q.alu_control;
    assign RD1E        = e_q.rd1;
    assign RD2E        = e_q.rd2;
    assign SignImmE    = e_q.sign_imm;
    assign RsE         = e_q.rs;
    assign RtE         = e_q.rt;
    assign RdE         = e_q.rd;
    assign StallCount  = stall_count_q;

endmodule
